// File: rtl/inv_key_schedule.sv
// inv_key_schedule -- backward AES-128 key expansion for the decryption path.
//
// Loaded with the round-10 key, it steps the schedule backward and presents
// round keys 10, 9, ..., 0, one per accepted valid/ready handshake, so the
// inverse cipher never has to hold the full expanded key.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      begin a backward walk (sampled only while idle)
//   last_key   round-10 key, word 0 in [127:96], sampled with start
//   key_ready  consumer accepts round_key this cycle
//   round_key  current round key, word 0 in [127:96]
//   round_idx  round number of round_key (10 down to 0)
//   key_valid  round_key/round_idx valid
//   busy       walk in progress (mirrors key_valid)
//   done       one-cycle pulse after the round-0 key is accepted

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Computing it keeps the table out of the source; synthesis
// flattens it to logic either way.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // a^254 is the inverse for a != 0 and yields 0 for a == 0, as required.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_reg;
    logic [127:0] round_key_reg;
    logic [3:0]   round_idx_reg;
    logic         key_valid_reg;
    logic         busy_reg;
    logic         done_reg;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [7:0]   rcon;
    logic [127:0] prev_key;

    assign k0 = round_key_reg[127:96];
    assign k1 = round_key_reg[95:64];
    assign k2 = round_key_reg[63:32];
    assign k3 = round_key_reg[31:0];

    // Words 1..3 of the previous round fall out of the XOR chain directly;
    // word 3 of the previous round then feeds the SubWord/RotWord path.
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign rot_word = {p3[23:0], p3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sbox u_sbox (
                .a (rot_word[8*gi +: 8]),
                .y (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    // Round constant of the round being undone; zero outside 1..10.
    always_comb begin
        rcon = 8'h00;
        case (round_idx_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0       = k0 ^ sub_word ^ {rcon, 24'h000000};
    assign prev_key = {p0, p1, p2, p3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            round_key_reg <= '0;
            round_idx_reg <= '0;
            key_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        round_key_reg <= last_key;
                        round_idx_reg <= 4'd10;
                        key_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    if (key_valid_reg && key_ready) begin
                        if (round_idx_reg == 4'd0) begin
                            key_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            round_key_reg <= prev_key;
                            round_idx_reg <= round_idx_reg - 4'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign round_key = round_key_reg;
    assign round_idx = round_idx_reg;
    assign key_valid = key_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
endmodule
